// File: rtl/x2050_ifs_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package x2050_ifs_pkg;

  localparam int unsigned TMO_CYCLES_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DRAIN = 3'd4,
    ST_ERR   = 3'd5
  } ifs_state_t;

  // A/B branch codes presented to the ROS
  localparam logic [1:0] FCN_READY       = 2'b00;
  localparam logic [1:0] FCN_ODD_REFETCH = 2'b01;
  localparam logic [1:0] FCN_EMPTY       = 2'b10;
  localparam logic [1:0] FCN_ERR         = 2'b11;

  // Equivalent to {err | ~full, err | (full & ptr & refetch)}
  function automatic logic [1:0] fetch_stat(input logic err, input logic full,
                                            input logic ptr, input logic refetch);
    if (err)                return FCN_ERR;
    else if (!full)         return FCN_EMPTY;
    else if (ptr & refetch) return FCN_ODD_REFETCH;
    else                    return FCN_READY;
  endfunction

endpackage

// File: rtl/x2050_ifs_tmo.sv
// Storage-ack timeout counter; expired is asserted on the last permitted cycle.
module x2050_ifs_tmo
  import x2050_ifs_pkg::*;
#(
  parameter int unsigned TMO_CYCLES = TMO_CYCLES_DEF
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned W = (TMO_CYCLES > 2) ? $clog2(TMO_CYCLES) : 1;
  localparam logic [W-1:0] LAST = W'(TMO_CYCLES - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge i_clk) begin
    if (i_reset || clear)
      cnt <= '0;
    else if (enable && !expired)
      cnt <= cnt + W'(1);
  end

  assign expired = enable && (cnt == LAST);

endmodule

// File: rtl/x2050_ifetch_seq.sv
// Instruction-fetch sequencer: one-word buffer, halfword pointer, storage handshake.
module x2050_ifetch_seq
  import x2050_ifs_pkg::*;
#(
  parameter int unsigned TMO_CYCLES = TMO_CYCLES_DEF
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_ros_advance,
  input  logic        i_fetch,
  input  logic        i_consume,
  input  logic        i_flush,
  input  logic [23:0] i_iar,
  input  logic        i_invalid_address,
  output logic        o_mem_req,
  output logic [23:0] o_mem_addr,
  input  logic        i_mem_gnt,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_data,
  output logic        o_ib_full,
  output logic [15:0] o_ib_half,
  output logic        o_refetch,
  output logic        o_err,
  output logic [1:0]  o_fetch_stat_fcn
);

  ifs_state_t  state_q, state_d;
  logic [23:0] addr_q, addr_d;
  logic [31:0] buf_q, buf_d;
  logic        ptr_q, ptr_d;
  logic        full_q, full_d;
  logic        refetch_q, refetch_d;
  logic        err_q, err_d;
  logic        cmd_fetch, cmd_consume, cmd_flush;
  logic        expired;
  logic        unused_iar0;

  assign unused_iar0 = i_iar[0];

  assign cmd_fetch   = i_ros_advance & i_fetch;
  assign cmd_consume = i_ros_advance & i_consume;
  assign cmd_flush   = i_ros_advance & i_flush;

  // Timeout restarts on every state change, so WAIT and DRAIN each get a full window
  x2050_ifs_tmo #(.TMO_CYCLES(TMO_CYCLES)) u_tmo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .clear   (state_q != state_d),
    .enable  ((state_q == ST_WAIT) || (state_q == ST_DRAIN)),
    .expired (expired)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      buf_q     <= '0;
      ptr_q     <= 1'b0;
      full_q    <= 1'b0;
      refetch_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      buf_q     <= buf_d;
      ptr_q     <= ptr_d;
      full_q    <= full_d;
      refetch_q <= refetch_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    buf_d     = buf_q;
    ptr_d     = ptr_q;
    full_d    = full_q;
    refetch_d = refetch_q;
    err_d     = err_q;
    if (cmd_flush) begin
      full_d    = 1'b0;
      refetch_d = 1'b1;
      state_d   = (state_q == ST_WAIT) ? ST_DRAIN : ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_HOLD, ST_ERR: begin
          if (cmd_fetch) begin
            full_d = 1'b0;
            if (i_invalid_address) begin
              state_d = ST_ERR;
              err_d   = 1'b1;
            end else begin
              addr_d  = {i_iar[23:2], 2'b00};
              ptr_d   = i_iar[1];
              state_d = ST_REQ;
              err_d   = 1'b0;
            end
          end else if (cmd_consume && full_q) begin
            if (!ptr_q) begin
              ptr_d = 1'b1;
            end else begin
              full_d  = 1'b0;
              addr_d  = addr_q + 24'd4;
              ptr_d   = 1'b0;
              state_d = ST_REQ;
              err_d   = 1'b0;
            end
          end
        end
        ST_REQ: begin
          if (i_mem_gnt) state_d = ST_WAIT;
        end
        ST_WAIT: begin
          if (i_mem_ack) begin
            buf_d     = i_mem_data;
            full_d    = 1'b1;
            refetch_d = 1'b0;
            state_d   = ST_HOLD;
          end else if (expired) begin
            state_d = ST_ERR;
            err_d   = 1'b1;
          end
        end
        ST_DRAIN: begin
          if (i_mem_ack || expired) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign o_mem_req        = (state_q == ST_REQ);
  assign o_mem_addr       = addr_q;
  assign o_ib_full        = full_q;
  assign o_ib_half        = ptr_q ? buf_q[15:0] : buf_q[31:16];
  assign o_refetch        = refetch_q;
  assign o_err            = err_q;
  assign o_fetch_stat_fcn = fetch_stat(err_q, full_q, ptr_q, refetch_q);

endmodule

// File: tb/tb_x2050_ifetch_seq.sv
// Scoreboard bench for x2050_ifetch_seq: expected addresses/halves queued at stimulus time.
module tb_x2050_ifetch_seq;

  logic        clk = 1'b0;
  logic        reset, ros_advance, fetch, consume, flush, invalid_address;
  logic        mem_gnt, mem_ack;
  logic [23:0] iar;
  logic [31:0] mem_data;
  logic        mem_req, ib_full, refetch, err;
  logic [23:0] mem_addr;
  logic [15:0] ib_half;
  logic [1:0]  fcn;

  int unsigned total = 0;
  int unsigned bad   = 0;

  logic [23:0] exp_addr[$];
  logic [15:0] exp_half[$];
  logic        model_ptr = 1'b0;
  logic [23:0] model_addr = '0;

  x2050_ifetch_seq #(.TMO_CYCLES(16)) dut (
    .i_clk             (clk),
    .i_reset           (reset),
    .i_ros_advance     (ros_advance),
    .i_fetch           (fetch),
    .i_consume         (consume),
    .i_flush           (flush),
    .i_iar             (iar),
    .i_invalid_address (invalid_address),
    .o_mem_req         (mem_req),
    .o_mem_addr        (mem_addr),
    .i_mem_gnt         (mem_gnt),
    .i_mem_ack         (mem_ack),
    .i_mem_data        (mem_data),
    .o_ib_full         (ib_full),
    .o_ib_half         (ib_half),
    .o_refetch         (refetch),
    .o_err             (err),
    .o_fetch_stat_fcn  (fcn)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_fetch(input logic [23:0] a, input logic inv);
    fetch = 1'b1; iar = a; invalid_address = inv;
    exp_half.delete();
    if (!inv) begin
      exp_addr.push_back({a[23:2], 2'b00});
      model_addr = {a[23:2], 2'b00};
      model_ptr  = a[1];
    end
    tick;
    fetch = 1'b0; invalid_address = 1'b0;
  endtask

  task automatic do_grant(input int dly);
    int n = 0;
    logic [23:0] e;
    while (mem_req !== 1'b1 && n < 20) begin tick; n++; end
    total++;
    if (mem_req !== 1'b1) begin bad++; $display("FAIL req_wait mem_req=%b exp=1", mem_req); end
    if (exp_addr.size() != 0) e = exp_addr.pop_front();
    else e = 'x;
    total++;
    if (mem_addr !== e) begin bad++; $display("FAIL req_addr got=%h exp=%h", mem_addr, e); end
    repeat (dly) begin
      tick;
      total++;
      if (mem_req !== 1'b1 || mem_addr !== e) begin
        bad++; $display("FAIL req_hold req=%b addr=%h exp=1/%h", mem_req, mem_addr, e);
      end
    end
    mem_gnt = 1'b1;
    tick;
    mem_gnt = 1'b0;
    total++;
    if (mem_req !== 1'b0) begin bad++; $display("FAIL req_drop mem_req=%b exp=0", mem_req); end
  endtask

  task automatic do_ack(input int dly, input logic [31:0] d);
    logic [15:0] e;
    repeat (dly - 1) tick;
    if (!model_ptr) exp_half.push_back(d[31:16]);
    exp_half.push_back(d[15:0]);
    mem_ack = 1'b1; mem_data = d;
    tick;
    mem_ack = 1'b0;
    total++;
    if (ib_full !== 1'b1) begin bad++; $display("FAIL ack_full got=%b exp=1", ib_full); end
    e = exp_half.pop_front();
    total++;
    if (ib_half !== e) begin bad++; $display("FAIL ack_half got=%h exp=%h", ib_half, e); end
  endtask

  task automatic do_consume;
    logic [15:0] e;
    logic        was_ptr;
    was_ptr = model_ptr;
    consume = 1'b1;
    if (was_ptr) begin
      model_addr = model_addr + 24'd4;
      exp_addr.push_back(model_addr);
      model_ptr = 1'b0;
    end else begin
      model_ptr = 1'b1;
    end
    tick;
    consume = 1'b0;
    if (!was_ptr) begin
      e = exp_half.pop_front();
      total++;
      if (ib_half !== e || ib_full !== 1'b1 || mem_req !== 1'b0) begin
        bad++; $display("FAIL consume_lo half=%h full=%b req=%b exp=%h/1/0", ib_half, ib_full, mem_req, e);
      end
    end else begin
      total++;
      if (ib_full !== 1'b0 || mem_req !== 1'b1 || fcn !== 2'b10) begin
        bad++; $display("FAIL consume_hi full=%b req=%b fcn=%b exp=0/1/10", ib_full, mem_req, fcn);
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick; tick;
    reset = 1'b0;
    total++;
    if (mem_req !== 1'b0 || ib_full !== 1'b0 || refetch !== 1'b0 || err !== 1'b0) begin
      bad++; $display("FAIL reset_flags req=%b full=%b refetch=%b err=%b exp=0000", mem_req, ib_full, refetch, err);
    end
    total++;
    if (mem_addr !== 24'h0 || ib_half !== 16'h0 || fcn !== 2'b10) begin
      bad++; $display("FAIL reset_data addr=%h half=%h fcn=%b exp=000000/0000/10", mem_addr, ib_half, fcn);
    end
    consume = 1'b1;
    tick;
    consume = 1'b0;
    total++;
    if (ib_full !== 1'b0 || mem_req !== 1'b0) begin
      bad++; $display("FAIL consume_empty full=%b req=%b exp=0/0", ib_full, mem_req);
    end
  endtask

  task automatic test_basic_fetch;
    do_fetch(24'h001002, 1'b0);
    do_grant(1);
    do_ack(3, 32'h12345678);
    total++;
    if (fcn !== 2'b00) begin bad++; $display("FAIL basic_fcn got=%b exp=00", fcn); end
  endtask

  task automatic test_consume;
    do_fetch(24'h001000, 1'b0);
    do_grant(0);
    do_ack(1, 32'h12345678);
    do_consume;
    do_consume;
    do_grant(2);
    do_ack(2, 32'h9ABCDEF0);
  endtask

  task automatic test_invalid;
    do_fetch(24'h123456, 1'b1);
    total++;
    if (mem_req !== 1'b0 || err !== 1'b1 || fcn !== 2'b11) begin
      bad++; $display("FAIL invalid req=%b err=%b fcn=%b exp=0/1/11", mem_req, err, fcn);
    end
    for (int i = 0; i < 3; i++) begin
      tick;
      total++;
      if (mem_req !== 1'b0) begin bad++; $display("FAIL invalid_noreq req=%b exp=0", mem_req); end
    end
    do_fetch(24'h000100, 1'b0);
    total++;
    if (err !== 1'b0) begin bad++; $display("FAIL err_clear got=%b exp=0", err); end
    do_grant(0);
    do_ack(1, 32'hA1A2B3B4);
  endtask

  task automatic test_flush;
    do_fetch(24'h002000, 1'b0);
    do_grant(0);
    flush = 1'b1;
    exp_half.delete();
    tick;
    flush = 1'b0;
    total++;
    if (ib_full !== 1'b0 || refetch !== 1'b1 || mem_req !== 1'b0) begin
      bad++; $display("FAIL flush full=%b refetch=%b req=%b exp=0/1/0", ib_full, refetch, mem_req);
    end
    tick;
    mem_ack = 1'b1; mem_data = 32'hDEADBEEF;
    tick;
    mem_ack = 1'b0;
    tick;
    total++;
    if (ib_full !== 1'b0 || mem_req !== 1'b0) begin
      bad++; $display("FAIL drain_discard full=%b req=%b exp=0/0", ib_full, mem_req);
    end
    do_fetch(24'h002004, 1'b0);
    total++;
    if (refetch !== 1'b1) begin bad++; $display("FAIL refetch_req got=%b exp=1", refetch); end
    do_grant(1);
    total++;
    if (refetch !== 1'b1) begin bad++; $display("FAIL refetch_wait got=%b exp=1", refetch); end
    do_ack(2, 32'h0BADCAFE);
    total++;
    if (refetch !== 1'b0) begin bad++; $display("FAIL refetch_clear got=%b exp=0", refetch); end
  endtask

  task automatic test_flush_ack_same;
    do_fetch(24'h003000, 1'b0);
    do_grant(0);
    flush = 1'b1; mem_ack = 1'b1; mem_data = 32'h55AA55AA;
    exp_half.delete();
    tick;
    flush = 1'b0; mem_ack = 1'b0;
    total++;
    if (ib_full !== 1'b0) begin bad++; $display("FAIL flush_ack full=%b exp=0", ib_full); end
    repeat (20) tick;
    total++;
    if (err !== 1'b0 || mem_req !== 1'b0) begin
      bad++; $display("FAIL drain_tmo err=%b req=%b exp=0/0", err, mem_req);
    end
    do_fetch(24'h003008, 1'b0);
    do_grant(0);
    do_ack(1, 32'h76543210);
  endtask

  task automatic test_timeout;
    do_fetch(24'h004000, 1'b0);
    do_grant(0);
    repeat (15) tick;
    total++;
    if (err !== 1'b0) begin bad++; $display("FAIL tmo_early err=%b exp=0", err); end
    tick;
    total++;
    if (err !== 1'b1 || fcn !== 2'b11 || mem_req !== 1'b0) begin
      bad++; $display("FAIL tmo err=%b fcn=%b req=%b exp=1/11/0", err, fcn, mem_req);
    end
  endtask

  task automatic test_wrap;
    do_fetch(24'hFFFFFE, 1'b0);
    do_grant(0);
    do_ack(1, 32'h11112222);
    do_consume;
    ros_advance = 1'b0;
    do_grant(1);
    do_ack(2, 32'h33334444);
    consume = 1'b1; flush = 1'b1;
    tick;
    consume = 1'b0; flush = 1'b0;
    total++;
    if (ib_full !== 1'b1 || ib_half !== 16'h3333) begin
      bad++; $display("FAIL no_advance full=%b half=%h exp=1/3333", ib_full, ib_half);
    end
    ros_advance = 1'b1;
  endtask

  task automatic test_reset_wait;
    do_fetch(24'h005000, 1'b0);
    do_grant(0);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    exp_half.delete();
    mem_ack = 1'b1; mem_data = 32'hFEEDFACE;
    tick;
    mem_ack = 1'b0;
    total++;
    if (ib_full !== 1'b0 || mem_req !== 1'b0 || mem_addr !== 24'h0 || ib_half !== 16'h0) begin
      bad++; $display("FAIL reset_wait full=%b req=%b addr=%h half=%h exp=0/0/000000/0000",
                      ib_full, mem_req, mem_addr, ib_half);
    end
  endtask

  initial begin
    reset = 1'b1; ros_advance = 1'b1; fetch = 1'b0; consume = 1'b0; flush = 1'b0;
    invalid_address = 1'b0; mem_gnt = 1'b0; mem_ack = 1'b0; iar = '0; mem_data = '0;
    test_reset;
    test_basic_fetch;
    test_consume;
    test_invalid;
    test_flush;
    test_flush_ack_same;
    test_timeout;
    test_wrap;
    test_reset_wait;
    total++;
    if (exp_addr.size() != 0) begin
      bad++; $display("FAIL addr_queue left=%0d exp=0", exp_addr.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/x2050_ifetch_seq.md
X2050_IFETCH_SEQ -- requirements
Module: x2050_ifetch_seq

Interface
REQ-001 SHALL have parameter TMO_CYCLES, default 16, which is the storage-ack timeout in clocks and SHALL be at least 2.
REQ-002 SHALL have port i_clk, input, 1 bit: clock.
REQ-003 SHALL have port i_reset, input, 1 bit: synchronous, active-high reset; the clock is i_clk.
REQ-004 SHALL have port i_ros_advance, input, 1 bit: ROS cycle enable; all commands are sampled only when it is high.
REQ-005 SHALL have port i_fetch, input, 1 bit: start an instruction fetch at i_iar.
REQ-006 SHALL have port i_consume, input, 1 bit: the current halfword has been used.
REQ-007 SHALL have port i_flush, input, 1 bit: branch taken; discard the buffer and any fetch in flight.
REQ-008 SHALL have port i_iar, input, 24 bits: instruction address; bit 0 is ignored.
REQ-009 SHALL have port i_invalid_address, input, 1 bit: i_iar is out of storage range.
REQ-010 SHALL have port o_mem_req, output, 1 bit: storage read request.
REQ-011 SHALL have port o_mem_addr, output, 24 bits: word-aligned read address.
REQ-012 SHALL have port i_mem_gnt, input, 1 bit: storage grant.
REQ-013 SHALL have port i_mem_ack, input, 1 bit: read data valid.
REQ-014 SHALL have port i_mem_data, input, 32 bits: storage word.
REQ-015 SHALL have port o_ib_full, output, 1 bit: the buffer holds a valid halfword.
REQ-016 SHALL have port o_ib_half, output, 16 bits: the current instruction halfword.
REQ-017 SHALL have port o_refetch, output, 1 bit: the current fetch was issued after a flush.
REQ-018 SHALL have port o_err, output, 1 bit: invalid address or timeout.
REQ-019 SHALL have port o_fetch_stat_fcn, output, 2 bits: A/B branch code for the ROS.

Function
REQ-020 SHALL implement the states IDLE, REQ, WAIT, HOLD, DRAIN and ERR.
REQ-021 In IDLE, HOLD or ERR, a sampled i_fetch with i_invalid_address=0 SHALL latch the word address {i_iar[23:2],2'b00} and the halfword pointer i_iar[1], and SHALL then go to REQ.
REQ-022 If i_invalid_address=1 at that point, the block SHALL go to ERR, SHALL set o_err=1 and SHALL NOT assert o_mem_req.
REQ-023 In REQ, o_mem_req SHALL be held at 1 with o_mem_addr stable until a cycle with i_mem_gnt=1, after which the block SHALL go to WAIT; the request SHALL drop in the cycle after the grant.
REQ-024 In WAIT, i_mem_ack SHALL load the 32-bit buffer, set o_ib_full=1 and go to HOLD; data SHALL be visible in the next cycle.
REQ-025 In WAIT, if no ack arrives within TMO_CYCLES cycles of entering WAIT, the block SHALL go to ERR with o_err=1.
REQ-026 o_ib_half SHALL be buffer[31:16] when the pointer is 0 and buffer[15:0] when the pointer is 1.
REQ-027 On i_consume in HOLD with pointer 0, the pointer SHALL become 1, the buffer SHALL stay full and no storage access SHALL occur.
REQ-028 On i_consume in HOLD with pointer 1, o_ib_full SHALL become 0, the word address SHALL increment by 4 (wrapping modulo 2^24), the pointer SHALL become 0, and the block SHALL go to REQ automatically.
REQ-029 i_consume while o_ib_full=0 SHALL be ignored.
REQ-030 On i_flush in any state, o_ib_full SHALL become 0, o_refetch SHALL be set, and the block SHALL go to IDLE; from WAIT it SHALL instead go to DRAIN.
REQ-031 DRAIN SHALL discard the next ack and then go to IDLE; DRAIN SHALL also go to IDLE on timeout, without raising an error.
REQ-032 If i_flush and i_mem_ack occur in the same cycle, the flush SHALL win and the data SHALL be discarded.
REQ-033 i_flush SHALL take priority over i_fetch, and i_fetch SHALL take priority over i_consume.
REQ-034 i_fetch during REQ or WAIT SHALL be ignored.
REQ-035 o_refetch SHALL be cleared when the next ack is accepted in WAIT.
REQ-036 o_err SHALL be cleared on entry to REQ.
REQ-037 o_fetch_stat_fcn SHALL be {o_err | ~o_ib_full, o_err | (o_ib_full & pointer & o_refetch)}.
REQ-038 All state SHALL update only when i_ros_advance=1, except that the REQ/WAIT/DRAIN handshakes and the timeout counter SHALL advance on every clock.

Reset
REQ-039 i_reset SHALL force the state to IDLE, with o_mem_req, o_ib_full, o_refetch, o_err, the pointer and the timeout counter at 0, and o_mem_addr, the buffer and o_ib_half at 0.
REQ-040 Reset during WAIT SHALL abandon the access, and a late ack SHALL be ignored while in IDLE.

Structure
REQ-041 The state enum, the fcn encodings and the default TMO_CYCLES SHALL be in package x2050_ifs_pkg.
REQ-042 The timeout counter SHALL be the sub-module x2050_ifs_tmo, with ports clear, enable and expired.

Verification
REQ-043 Scenario: i_fetch with iar=0x001002, grant after 1 cycle, ack after 3 cycles with data 0x12345678 -> o_mem_addr=0x001000, o_ib_half=0x5678, fcn=00.
REQ-044 Scenario: from HOLD at pointer 0, two i_consume -> halves 0x1234 then 0x5678, then auto-request to 0x001004 and fcn=10 while empty.
REQ-045 Scenario: i_fetch with i_invalid_address=1 -> no o_mem_req, o_err=1, fcn=11.
REQ-046 Scenario: i_flush in WAIT followed by ack 2 cycles later -> data discarded, IDLE, then the next fetch shows o_refetch=1 until its ack.
REQ-047 Scenario: no ack for TMO_CYCLES=16 cycles -> ERR on cycle 16 with o_err=1.
REQ-048 Scenario: iar=0xFFFFFE, consume -> next address 0x000000.
